// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash master.
package spi_flash_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SHIFT     = 3'd2,
    WAIT_NEXT = 3'd3,
    GAP       = 3'd4
  } state_t;

endpackage

// File: rtl/spi_flash_master_clk_div.sv
// SCK half-period divider: emits a one-cycle half_tick in the last CLK
// cycle of every half-period while enabled, and restarts from 0 whenever
// it is disabled so every byte begins with a full low half.
module spi_flash_master_clk_div
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic half_tick
);

  logic [CNT_W-1:0] div_cnt_reg;

  assign half_tick = en && (div_cnt_reg == CNT_W'(CLK_DIV - 1));

  // Free-running half-period counter, held at zero while disabled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt_reg <= '0;
    end else if (!en || half_tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_master.sv
// Mode-0 SPI master for the boot flash, feeding the PolarFire SPI pad macro.
// Optional build macro: SPI_OWNER_CHECK_EN (pad ownership gating and frame
// abort on loss of ownership). Without it, spi_owner is ignored.
module spi_flash_master
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       abort_err,
  output logic       spi_clk_o,
  output logic       spi_clk_oe,
  output logic       spi_d_o,
  output logic       spi_d_oe,
  output logic       spi_ss_o,
  output logic       spi_ss_oe,
  input  logic       spi_d_i,
  input  logic       spi_owner
);

  state_t state_reg, state_next;

  logic                sck_reg;
  logic                run_reg;
  logic                rx_valid_reg;
  logic                last_reg;
  logic                abort_err_reg;
  logic [SPI_BITS-1:0] tx_shift_reg;
  logic [SPI_BITS-1:0] rx_shift_reg;
  logic [SPI_BITS-1:0] rx_data_reg;
  logic [SPI_BITS-1:0] rx_assembled;
  logic [2:0]          bit_cnt_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic half_tick;
  logic owner_ok;
  logic pad_oe;
  logic framing;
  logic handshake;
  logic byte_done;
  logic abort;

`ifdef SPI_OWNER_CHECK_EN
  logic owner_reg;

  // One-stage registered copy of pad ownership drives all output enables.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) owner_reg <= 1'b1;
    else       owner_reg <= spi_owner;
  end

  assign owner_ok = spi_owner;
  assign pad_oe   = owner_reg;
`else
  logic unused_owner;
  assign unused_owner = spi_owner;
  assign owner_ok     = 1'b1;
  assign pad_oe       = 1'b1;
`endif

  spi_flash_master_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .CLK       (CLK),
    .RESET     (RESET),
    .en        (state_reg == SHIFT),
    .half_tick (half_tick)
  );

  assign framing      = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == WAIT_NEXT);
  assign abort        = framing && !owner_ok;
  assign handshake    = tx_valid && tx_ready;
  assign rx_assembled = {rx_shift_reg[SPI_BITS-2:0], spi_d_i};
  assign byte_done    = (state_reg == SHIFT) && half_tick && sck_reg && (bit_cnt_reg == 3'd0);

  assign spi_clk_o  = sck_reg;
  assign spi_d_o    = tx_shift_reg[SPI_BITS-1];
  assign spi_clk_oe = pad_oe;
  assign spi_d_oe   = pad_oe;
  assign spi_ss_oe  = pad_oe;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign abort_err  = abort_err_reg;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; loss of pad ownership beats everything mid-frame.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (handshake) state_next = SETUP;
      SETUP:     if (abort) state_next = GAP;
                 else if (cnt_reg == '0) state_next = SHIFT;
      SHIFT:     if (abort) state_next = GAP;
                 else if (byte_done) state_next = last_reg ? GAP : WAIT_NEXT;
      WAIT_NEXT: if (abort) state_next = GAP;
                 else if (handshake) state_next = SHIFT;
      GAP:       if (cnt_reg == '0) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from state. rx_valid_reg is high only in the first
  // WAIT_NEXT cycle, so it keeps tx_ready low there and a new byte can
  // never be accepted alongside the rx_valid pulse.
  always_comb begin
    busy     = (state_reg != IDLE);
    spi_ss_o = !framing;
    tx_ready = 1'b0;
    if (run_reg && owner_ok) begin
      if (state_reg == IDLE) tx_ready = 1'b1;
      if ((state_reg == WAIT_NEXT) && !rx_valid_reg) tx_ready = 1'b1;
    end
  end

  // Shift datapath, SCK phase and setup/gap counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_reg       <= 1'b0;
      sck_reg       <= 1'b0;
      rx_valid_reg  <= 1'b0;
      last_reg      <= 1'b0;
      abort_err_reg <= 1'b0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      bit_cnt_reg   <= '0;
      cnt_reg       <= '0;
    end else begin
      run_reg      <= 1'b1;
      rx_valid_reg <= 1'b0;
      if (abort) begin
        sck_reg       <= 1'b0;
        cnt_reg       <= CNT_W'(CS_GAP - 1);
        abort_err_reg <= 1'b1;
      end else if (handshake) begin
        tx_shift_reg  <= tx_data;
        last_reg      <= tx_last;
        bit_cnt_reg   <= 3'(SPI_BITS - 1);
        cnt_reg       <= CNT_W'(CS_SETUP - 1);
        abort_err_reg <= 1'b0;
      end else begin
        case (state_reg)
          SETUP, GAP: begin
            if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
          end
          SHIFT: begin
            if (half_tick && !sck_reg) begin
              sck_reg <= 1'b1;
            end else if (half_tick) begin
              // End of high half: sample MISO, drop SCK, advance MOSI.
              sck_reg      <= 1'b0;
              rx_shift_reg <= rx_assembled;
              if (bit_cnt_reg == 3'd0) begin
                rx_data_reg  <= rx_assembled;
                rx_valid_reg <= 1'b1;
                cnt_reg      <= CNT_W'(CS_GAP - 1);
              end else begin
                bit_cnt_reg  <= bit_cnt_reg - 1'b1;
                tx_shift_reg <= {tx_shift_reg[SPI_BITS-2:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
